// File: rtl/fdd_motor_ctrl.sv
// -----------------------------------------------------------------------------
// fdd_motor_ctrl
//   Per-drive spindle sequencer for a 4-drive floppy subsystem. Each drive runs
//   its own OFF/SPINUP/RUN/COAST state machine clocked by a shared 1 ms tick.
//   A motor request starts a spin-up lasting SPINUP_REV revolutions, after which
//   motor_run is raised. When the request drops the motor coasts for
//   TIMEOUT_REV revolutions before stopping. A missing disk forces the drive OFF.
//
// Optional feature macro: FDD_INDEX_EN
//   defined   : INDEXn pulses low for INDEX_MS ms per revolution of the drive
//               selected by USEL.
//   undefined : INDEXn is held at 1.
//
// Ports
//   clk           in   1  system clock
//   reset_n       in   1  synchronous reset, active low
//   motor_req     in   4  per-drive motor request (level)
//   disk_present  in   4  per-drive image mounted and valid (level)
//   USEL          in   2  selected drive for INDEXn
//   motor_run     out  4  per-drive spun-up flag (RUN or COAST), registered
//   spinning      out  4  per-drive spindle active (not OFF), registered
//   INDEXn        out  1  index pulse of selected drive, active low, registered
// -----------------------------------------------------------------------------
module fdd_motor_ctrl #(
  parameter int TICK_DIV    = 21477,
  parameter int REV_MS      = 200,
  parameter int INDEX_MS    = 4,
  parameter int SPINUP_REV  = 3,
  parameter int TIMEOUT_REV = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] motor_req,
  input  logic [3:0] disk_present,
  input  logic [1:0] USEL,
  output logic [3:0] motor_run,
  output logic [3:0] spinning,
  output logic       INDEXn
);

  localparam int MAX_REV = (SPINUP_REV > TIMEOUT_REV) ? SPINUP_REV : TIMEOUT_REV;
  localparam int REV_W   = $clog2(MAX_REV + 1);
  localparam int PH_W    = (REV_MS > 1) ? $clog2(REV_MS) : 1;
  localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Elaboration-time parameter sanity checks
  if (TICK_DIV < 2) begin : g_chk_tick
    $error("fdd_motor_ctrl: TICK_DIV must be >= 2");
  end
  if (REV_MS < 2) begin : g_chk_rev
    $error("fdd_motor_ctrl: REV_MS must be >= 2");
  end
  if ((INDEX_MS < 1) || (INDEX_MS >= REV_MS)) begin : g_chk_index
    $error("fdd_motor_ctrl: INDEX_MS must be in 1..REV_MS-1");
  end
  if ((SPINUP_REV < 1) || (TIMEOUT_REV < 1)) begin : g_chk_revs
    $error("fdd_motor_ctrl: SPINUP_REV and TIMEOUT_REV must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_COAST  = 2'd3
  } state_e;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick_s;

  state_e           state_q [4];
  state_e           state_d [4];
  logic [PH_W-1:0]  phase_q [4];
  logic [PH_W-1:0]  phase_d [4];
  logic [REV_W-1:0] rev_q   [4];
  logic [REV_W-1:0] rev_d   [4];
  logic [3:0]       wrap_s;

  logic [3:0]       run_q, run_d;
  logic [3:0]       spin_q, spin_d;
  logic             index_q, index_d;

  // Free-running prescaler producing the 1 ms tick
  always_comb begin
    tick_s = (presc_q == PS_W'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = {PS_W{1'b0}};
    end else begin
      presc_d = presc_q + {{(PS_W-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= {PS_W{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-drive phase/revolution counters and state machine next-state logic
  always_comb begin
    wrap_s = 4'b0000;
    run_d  = 4'b0000;
    spin_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      phase_d[i] = phase_q[i];
      rev_d[i]   = rev_q[i];

      // Phase only advances while the spindle turns
      if ((state_q[i] != ST_OFF) && tick_s) begin
        if (phase_q[i] == PH_W'(REV_MS - 1)) begin
          phase_d[i] = {PH_W{1'b0}};
          wrap_s[i]  = 1'b1;
        end else begin
          phase_d[i] = phase_q[i] + {{(PH_W-1){1'b0}}, 1'b1};
        end
      end else begin
        phase_d[i] = phase_q[i];
      end

      if (wrap_s[i]) begin
        rev_d[i] = rev_q[i] + {{(REV_W-1){1'b0}}, 1'b1};
      end else begin
        rev_d[i] = rev_q[i];
      end

      // A missing disk overrides every other condition
      if (!disk_present[i]) begin
        state_d[i] = ST_OFF;
        phase_d[i] = {PH_W{1'b0}};
        rev_d[i]   = {REV_W{1'b0}};
      end else begin
        case (state_q[i])
          ST_OFF: begin
            if (motor_req[i]) begin
              state_d[i] = ST_SPINUP;
            end else begin
              state_d[i] = ST_OFF;
            end
            // Counters are parked at zero so spin-up always starts a fresh revolution
            phase_d[i] = {PH_W{1'b0}};
            rev_d[i]   = {REV_W{1'b0}};
          end
          ST_SPINUP: begin
            // Request drop wins over spin-up completion in the same cycle
            if (!motor_req[i]) begin
              state_d[i] = ST_OFF;
              phase_d[i] = {PH_W{1'b0}};
              rev_d[i]   = {REV_W{1'b0}};
            end else if (wrap_s[i] && (rev_q[i] == REV_W'(SPINUP_REV - 1))) begin
              state_d[i] = ST_RUN;
            end else begin
              state_d[i] = ST_SPINUP;
            end
          end
          ST_RUN: begin
            // Coasting restarts the revolution count but keeps the phase running
            if (!motor_req[i]) begin
              state_d[i] = ST_COAST;
              rev_d[i]   = {REV_W{1'b0}};
            end else begin
              state_d[i] = ST_RUN;
            end
          end
          ST_COAST: begin
            // Re-request wins over the run-on timeout in the same cycle
            if (motor_req[i]) begin
              state_d[i] = ST_RUN;
            end else if (wrap_s[i] && (rev_q[i] == REV_W'(TIMEOUT_REV - 1))) begin
              state_d[i] = ST_OFF;
              phase_d[i] = {PH_W{1'b0}};
              rev_d[i]   = {REV_W{1'b0}};
            end else begin
              state_d[i] = ST_COAST;
            end
          end
          default: begin
            state_d[i] = ST_OFF;
            phase_d[i] = {PH_W{1'b0}};
            rev_d[i]   = {REV_W{1'b0}};
          end
        endcase
      end

      // Outputs follow the next state so they change on the same edge as the state
      run_d[i]  = (state_d[i] == ST_RUN) || (state_d[i] == ST_COAST);
      spin_d[i] = (state_d[i] != ST_OFF);
    end
  end

  // Per-drive state, counters and registered flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_OFF;
        phase_q[i] <= {PH_W{1'b0}};
        rev_q[i]   <= {REV_W{1'b0}};
      end
      run_q  <= 4'b0000;
      spin_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        phase_q[i] <= phase_d[i];
        rev_q[i]   <= rev_d[i];
      end
      run_q  <= run_d;
      spin_q <= spin_d;
    end
  end

`ifdef FDD_INDEX_EN
  // Index pulse: low during the first INDEX_MS ms of each revolution of the selected drive
  always_comb begin
    if (spin_q[USEL] && (phase_q[USEL] < PH_W'(INDEX_MS))) begin
      index_d = 1'b0;
    end else begin
      index_d = 1'b1;
    end
  end
`else
  logic unused_usel_s;
  assign unused_usel_s = ^USEL;

  // Index output disabled: held inactive
  always_comb begin
    index_d = 1'b1;
  end
`endif

  // Index output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      index_q <= 1'b1;
    end else begin
      index_q <= index_d;
    end
  end

  assign motor_run = run_q;
  assign spinning  = spin_q;
  assign INDEXn    = index_q;

endmodule

// File: tb/tb_fdd_motor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fdd_motor_ctrl
//   Self-checking bench for fdd_motor_ctrl with a small timebase
//   (TICK_DIV=4, REV_MS=10, INDEX_MS=2, SPINUP_REV=3, TIMEOUT_REV=2).
//   One revolution is 40 clk; spin-up is 3 revolutions, run-on is 2.
//   Expected results are pushed to a scoreboard queue when stimulus is applied
//   and popped when the corresponding DUT behaviour has been observed.
// -----------------------------------------------------------------------------
module tb_fdd_motor_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] motor_req;
  logic [3:0] disk_present;
  logic [1:0] USEL;
  logic [3:0] motor_run;
  logic [3:0] spinning;
  logic       INDEXn;

  typedef struct {
    string name;
    int    lo;
    int    hi;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  fdd_motor_ctrl #(
    .TICK_DIV   (4),
    .REV_MS     (10),
    .INDEX_MS   (2),
    .SPINUP_REV (3),
    .TIMEOUT_REV(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .motor_req   (motor_req),
    .disk_present(disk_present),
    .USEL        (USEL),
    .motor_run   (motor_run),
    .spinning    (spinning),
    .INDEXn      (INDEXn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for motor_run[d]; lat = edges counted, -1 on timeout
  task automatic wait_run(input int d, output int lat);
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (motor_run[d]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    motor_req    = 4'hF;
    disk_present = 4'hF;
    USEL         = 2'd0;
    sb.push_back('{"reset_motor_run", 0, 0});
    sb.push_back('{"reset_spinning", 0, 0});
    sb.push_back('{"reset_indexn", 1, 1});
    repeat (3) step();
    e = sb.pop_front(); n_vec++;
    if (int'(motor_run) < e.lo || int'(motor_run) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, motor_run, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (int'(spinning) < e.lo || int'(spinning) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, spinning, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (int'(INDEXn) < e.lo || int'(INDEXn) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, INDEXn, e.lo, e.hi);
    end
    motor_req = 4'h0;
    reset_n   = 1'b1;
    step();
  endtask

  task automatic test_spinup();
    int   lat;
    int   sp1;
    logic others;
    lat = -1; sp1 = 0; others = 1'b0;
    motor_req[0] = 1'b1;
    sb.push_back('{"spinup_latency", 117, 121});
    sb.push_back('{"spinning_next_clk", 1, 1});
    sb.push_back('{"other_drives_idle", 0, 0});
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 1) sp1 = int'(spinning[0]);
      others = others | (|motor_run[3:1]) | (|spinning[3:1]);
      if (motor_run[0]) begin
        lat = c;
        break;
      end
    end
    e = sb.pop_front(); n_vec++;
    if (lat < e.lo || lat > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, lat, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (sp1 < e.lo || sp1 > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, sp1, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (int'(others) < e.lo || int'(others) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, others, e.lo, e.hi);
    end
  endtask

  // Entered right after motor_run[0] rose, i.e. at a revolution boundary
  task automatic test_coast();
    int len;
    int spn;
    len = -1; spn = 1;
    motor_req[0] = 1'b0;
    sb.push_back('{"coast_length", 80, 80});
    sb.push_back('{"coast_end_spinning", 0, 0});
    for (int c = 1; c <= 200; c++) begin
      step();
      if (!motor_run[0]) begin
        len = c;
        spn = int'(spinning[0]);
        break;
      end
    end
    e = sb.pop_front(); n_vec++;
    if (len < e.lo || len > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, len, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (spn < e.lo || spn > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, spn, e.lo, e.hi);
    end
  endtask

  task automatic test_rerequest();
    int   lat;
    logic held;
    motor_req[0] = 1'b1;
    wait_run(0, lat);
    held = (lat > 0);
    motor_req[0] = 1'b0;
    sb.push_back('{"rerequest_holds_run", 1, 1});
    repeat (40) begin
      step();
      held = held & motor_run[0];
    end
    motor_req[0] = 1'b1;
    repeat (100) begin
      step();
      held = held & motor_run[0] & spinning[0];
    end
    e = sb.pop_front(); n_vec++;
    if (int'(held) < e.lo || int'(held) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, held, e.lo, e.hi);
    end
  endtask

  task automatic test_abort();
    int   obs;
    int   spn;
    int   lat;
    logic ran;
    // Reset while drive 0 is running aborts in one cycle
    sb.push_back('{"midop_reset", 0, 0});
    reset_n = 1'b0;
    step();
    obs = int'({motor_run, spinning});
    reset_n = 1'b1;
    motor_req = 4'h0;
    e = sb.pop_front(); n_vec++;
    if (obs < e.lo || obs > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, obs, e.lo, e.hi);
    end
    step();
    // Request dropped 60 clk into spin-up
    motor_req[0] = 1'b1;
    ran = 1'b0;
    sb.push_back('{"abort_spinning_next", 0, 0});
    sb.push_back('{"abort_run_never", 0, 0});
    repeat (60) begin
      step();
      ran = ran | motor_run[0];
    end
    motor_req[0] = 1'b0;
    step();
    spn = int'(spinning[0]);
    ran = ran | motor_run[0];
    repeat (150) begin
      step();
      ran = ran | motor_run[0];
    end
    e = sb.pop_front(); n_vec++;
    if (spn < e.lo || spn > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, spn, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (int'(ran) < e.lo || int'(ran) > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, ran, e.lo, e.hi);
    end
    // Disk removed while running
    motor_req[0] = 1'b1;
    wait_run(0, lat);
    sb.push_back('{"disk_removed", 0, 0});
    disk_present[0] = 1'b0;
    step();
    obs = (lat > 0) ? int'({motor_run[0], spinning[0]}) : -1;
    e = sb.pop_front(); n_vec++;
    if (obs < e.lo || obs > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, obs, e.lo, e.hi);
    end
    disk_present = 4'hF;
    motor_req    = 4'h0;
    step();
  endtask

  task automatic test_index();
    int lat;
    int lows;
    int obs;
    USEL = 2'd0;
    motor_req[0] = 1'b1;
    wait_run(0, lat);
    step();
`ifdef FDD_INDEX_EN
    sb.push_back('{"index_low_clks_120", 24, 24});
`else
    sb.push_back('{"index_low_clks_120", 0, 0});
`endif
    sb.push_back('{"index_usel_next_clk", 1, 1});
    sb.push_back('{"index_off_drive_low_clks", 0, 0});
    lows = (lat > 0) ? 0 : -1000;
    repeat (120) begin
      step();
      lows = lows + int'(!INDEXn);
    end
    e = sb.pop_front(); n_vec++;
    if (lows < e.lo || lows > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, lows, e.lo, e.hi);
    end
    // Park drive 0 inside its index window, then switch to the idle drive 1
    for (int c = 0; c < 40; c++) begin
      if (dut.phase_q[0] == 4'd0) break;
      step();
    end
    USEL = 2'd1;
    step();
    obs = int'(INDEXn);
    e = sb.pop_front(); n_vec++;
    if (obs < e.lo || obs > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, obs, e.lo, e.hi);
    end
    lows = 0;
    repeat (40) begin
      step();
      lows = lows + int'(!INDEXn);
    end
    e = sb.pop_front(); n_vec++;
    if (lows < e.lo || lows > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, lows, e.lo, e.hi);
    end
    motor_req = 4'h0;
    USEL = 2'd0;
  endtask

  task automatic test_concurrency();
    int r0;
    int r3;
    reset_pulse();
    r0 = -1; r3 = -1;
    motor_req = 4'b0001;
    sb.push_back('{"concurrent_drive0", 117, 121});
    sb.push_back('{"concurrent_drive3", 117, 121});
    for (int c = 1; c <= 400; c++) begin
      step();
      if (c == 10) motor_req[3] = 1'b1;
      if ((r0 < 0) && motor_run[0]) r0 = c;
      if ((r3 < 0) && motor_run[3]) r3 = c - 10;
      if ((r0 >= 0) && (r3 >= 0)) break;
    end
    e = sb.pop_front(); n_vec++;
    if (r0 < e.lo || r0 > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, r0, e.lo, e.hi);
    end
    e = sb.pop_front(); n_vec++;
    if (r3 < e.lo || r3 > e.hi) begin
      n_err++; $display("FAIL %s: observed %0d, expected %0d..%0d", e.name, r3, e.lo, e.hi);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    motor_req    = 4'h0;
    disk_present = 4'h0;
    USEL         = 2'd0;
    test_reset();
    test_spinup();
    test_coast();
    test_rerequest();
    test_abort();
    test_index();
    test_concurrency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
